// File: rtl/run_control_pkg.sv
// Shared types for the Start/Ack run-control responder: FSM state encoding and reset state.
package run_control_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        INIT  = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } run_state_t;

    localparam run_state_t RESET_STATE = IDLE;

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating cycle counter with synchronous clear and enable; count is registered, 1-cycle update.
// tc_o flags count == TC_VALUE so the caller can act on the same edge the count reaches TC_VALUE+1.
module run_cycle_counter #(
    parameter int               CNT_W    = 16,
    parameter logic [CNT_W-1:0] TC_VALUE = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == TC_VALUE);

endmodule

// File: rtl/run_control.sv
// Start/Ack program-run responder: PcInit 1 cycle after Start falls, Run until Halt, then Ack held.
// Optional RUN-cycle watchdog compiled in with RUN_CONTROL_WATCHDOG_EN; all outputs registered.
module run_control
    import run_control_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int WDOG_LIMIT = 4096
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    output logic             PcInit,
    output logic             Run,
    output logic             Ack,
    output logic             Timeout,
    output logic [CNT_W-1:0] CycleCount
);

    localparam logic [CNT_W-1:0] WDOG_TC = CNT_W'(WDOG_LIMIT - 1);

    run_state_t state_q, state_d;
    logic       pcinit_q, run_q, ack_q;
    logic       wdog_tc;
    logic       wdog_fire;
    logic       cnt_clr;
    logic       cnt_en;

`ifdef RUN_CONTROL_WATCHDOG_EN
    // Halt on the limit edge takes priority, so the timeout only fires without it.
    assign wdog_fire = (state_q == RUN) && !Halt && wdog_tc;
`else
    logic wdog_tc_unused;
    assign wdog_tc_unused = wdog_tc;
    assign wdog_fire      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (Start) state_d = ARMED;
            ARMED:   if (!Start) state_d = INIT;
            INIT:    state_d = RUN;
            RUN:     if (Halt || wdog_fire) state_d = DONE;
            DONE:    if (Start) state_d = ARMED;
            default: state_d = RESET_STATE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= RESET_STATE;
            pcinit_q <= 1'b0;
            run_q    <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcinit_q <= (state_d == INIT);
            run_q    <= (state_d == RUN);
            ack_q    <= (state_d == DONE);
        end
    end

    // Clearing on entry to INIT makes CycleCount read 0 while PcInit is high.
    assign cnt_clr = (state_d == INIT);
    assign cnt_en  = (state_q == RUN);

    run_cycle_counter #(
        .CNT_W    (CNT_W),
        .TC_VALUE (WDOG_TC)
    ) u_cycle_counter (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (CycleCount),
        .tc_o    (wdog_tc)
    );

`ifdef RUN_CONTROL_WATCHDOG_EN
    logic timeout_q, timeout_d;

    always_comb begin
        timeout_d = timeout_q;
        if (state_d == INIT) begin
            timeout_d = 1'b0;
        end else if (wdog_fire) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign Timeout = timeout_q;
`else
    assign Timeout = 1'b0;
`endif

    assign PcInit = pcinit_q;
    assign Run    = run_q;
    assign Ack    = ack_q;

endmodule
